// File: rtl/pipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipo_pkg
// Description : Shared operation encodings for the universal PIPO register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipo_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HOLD = 3'b000;
    localparam op_t OP_LOAD = 3'b001;
    localparam op_t OP_CLR  = 3'b010;
    localparam op_t OP_INC  = 3'b011;
    localparam op_t OP_DEC  = 3'b100;
    localparam op_t OP_SHL  = 3'b101;
    localparam op_t OP_SHR  = 3'b110;
    localparam op_t OP_ADD  = 3'b111;

    // True for the operations that can raise the sticky overflow flag.
    function automatic logic op_is_arith(input op_t op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_ADD);
    endfunction

endpackage : pipo_pkg
`default_nettype wire

// File: rtl/pipo_univ_nxt.sv
`default_nettype none
// ============================================================================
// Module      : pipo_univ_nxt
// Description : Next-state logic for pipo_univ: next dout/sout and ovf set/clear.
//               Saturating arithmetic when PIPO_UNIV_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pipo_univ_nxt
    import pipo_pkg::*;
#(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] dout_i,
    input  logic [W-1:0] din_i,
    input  logic         sin_i,
    input  logic         sout_i,
    output logic [W-1:0] dout_o,
    output logic         sout_o,
    output logic         ovf_set_o,
    output logic         ovf_clr_o
);

`ifdef PIPO_UNIV_SAT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    localparam logic [W-1:0] c_one  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] c_ones = {W{1'b1}};

    op_t          w_op;
    logic         w_all_ones;
    logic         w_is_zero;
    logic [W:0]   w_sum;

    assign w_op       = op_t'(op_i);
    assign w_all_ones = &dout_i;
    assign w_is_zero  = ~|dout_i;
    assign w_sum      = {1'b0, dout_i} + {1'b0, din_i};

    always_comb begin
        dout_o    = dout_i;
        sout_o    = sout_i;
        ovf_set_o = 1'b0;
        ovf_clr_o = 1'b0;
        case (w_op)
            OP_LOAD: begin
                dout_o    = din_i;
                ovf_clr_o = 1'b1;
            end
            OP_CLR: begin
                dout_o    = RST_VAL;
                sout_o    = 1'b0;
                ovf_clr_o = 1'b1;
            end
            OP_INC: begin
                if (w_all_ones) begin
                    ovf_set_o = 1'b1;
                    dout_o    = c_sat_en ? c_ones : '0;
                end else begin
                    dout_o    = dout_i + c_one;
                end
            end
            OP_DEC: begin
                if (w_is_zero) begin
                    ovf_set_o = 1'b1;
                    dout_o    = c_sat_en ? '0 : c_ones;
                end else begin
                    dout_o    = dout_i - c_one;
                end
            end
            OP_SHL: begin
                dout_o = {dout_i[W-2:0], sin_i};
                sout_o = dout_i[W-1];
            end
            OP_SHR: begin
                dout_o = {sin_i, dout_i[W-1:1]};
                sout_o = dout_i[0];
            end
            OP_ADD: begin
                // Carry-out of the W+1 bit sum is the overflow condition.
                if (w_sum[W]) begin
                    ovf_set_o = 1'b1;
                    dout_o    = c_sat_en ? c_ones : w_sum[W-1:0];
                end else begin
                    dout_o    = w_sum[W-1:0];
                end
            end
            default: begin
                dout_o = dout_i;
            end
        endcase
    end

endmodule : pipo_univ_nxt
`default_nettype wire

// File: rtl/pipo_univ.sv
`default_nettype none
// ============================================================================
// Module      : pipo_univ
// Description : Universal parallel-in/parallel-out register (load, clear,
//               inc, dec, shift, add) with zero flag and sticky overflow.
//               Define PIPO_UNIV_SAT_EN for saturating arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module pipo_univ
    import pipo_pkg::*;
#(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   op,
    input  logic [W-1:0] din,
    input  logic         sin,
    output logic [W-1:0] dout,
    output logic         zero,
    output logic         sout,
    output logic         ovf
);

    logic [W-1:0] r_dout_q;
    logic         r_sout_q;
    logic         r_ovf_q;

    logic [W-1:0] w_dout_d;
    logic         w_sout_d;
    logic         w_ovf_d;
    logic         w_ovf_set;
    logic         w_ovf_clr;

    pipo_univ_nxt #(
        .W       (W),
        .RST_VAL (RST_VAL)
    ) u_nxt (
        .op_i      (op),
        .dout_i    (r_dout_q),
        .din_i     (din),
        .sin_i     (sin),
        .sout_i    (r_sout_q),
        .dout_o    (w_dout_d),
        .sout_o    (w_sout_d),
        .ovf_set_o (w_ovf_set),
        .ovf_clr_o (w_ovf_clr)
    );

    // Clear wins over set; the two are never raised together by one op.
    assign w_ovf_d = w_ovf_clr ? 1'b0 : (w_ovf_set | r_ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_q <= RST_VAL;
            r_sout_q <= 1'b0;
            r_ovf_q  <= 1'b0;
        end else begin
            r_dout_q <= w_dout_d;
            r_sout_q <= w_sout_d;
            r_ovf_q  <= w_ovf_d;
        end
    end

    assign dout = r_dout_q;
    assign sout = r_sout_q;
    assign ovf  = r_ovf_q;
    assign zero = (r_dout_q == '0);

endmodule : pipo_univ
`default_nettype wire
